// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module  : reg_file_pkg
// Brief   : Shared FunSel encodings and select-width helper for reg_file_param.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    typedef enum logic [2:0] {
        FS_DEC       = 3'b000,
        FS_INC       = 3'b001,
        FS_LOAD      = 3'b010,
        FS_CLR       = 3'b011,
        FS_LOADLO_ZX = 3'b100,
        FS_WRLO      = 3'b101,
        FS_WRHI      = 3'b110,
        FS_LOADLO_SX = 3'b111
    } fun_sel_e;

    // A single-entry bank still needs a one-bit select bus.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_param_rf_cell.sv
// ============================================================================
// Module  : rf_cell
// Brief   : One WIDTH-bit register with sync reset, active-high enable and the
//           FunSel count/load/clear/half-word datapath.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rf_cell
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [2:0]       i_fun_sel,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    localparam int c_H = WIDTH / 2;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        if (i_en) begin
            case (i_fun_sel)
                FS_DEC:       w_next = r_q - WIDTH'(1);
                FS_INC:       w_next = r_q + WIDTH'(1);
                FS_LOAD:      w_next = i_data;
                FS_CLR:       w_next = '0;
                FS_LOADLO_ZX: w_next = {{c_H{1'b0}}, i_data[c_H-1:0]};
                FS_WRLO:      w_next = {r_q[WIDTH-1:c_H], i_data[c_H-1:0]};
                FS_WRHI:      w_next = {i_data[c_H-1:0], r_q[c_H-1:0]};
                FS_LOADLO_SX: w_next = {{c_H{i_data[c_H-1]}}, i_data[c_H-1:0]};
                default:      w_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= w_next;
    end

    assign o_q = r_q;

endmodule : rf_cell

`default_nettype wire

// File: rtl/reg_file_param.sv
// ============================================================================
// Module  : reg_file_param
// Brief   : Parametrised R/S register file with multi-port reads and zero flags.
//           Define REG_FILE_OUT_REG_EN to register Out/OutZ (1-cycle reads).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_param
    import reg_file_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int NUM_GP  = 4,
    parameter  int NUM_SCR = 4,
    parameter  int NUM_RD  = 2,
    localparam int SELW    = sel_width(NUM_GP + NUM_SCR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [2:0]               i_fun_sel,
    input  logic [NUM_GP-1:0]        i_reg_sel,
    input  logic [NUM_SCR-1:0]       i_scr_sel,
    input  logic [NUM_RD*SELW-1:0]   i_out_sel,
    output logic [NUM_RD*WIDTH-1:0]  o_out,
    output logic [NUM_RD-1:0]        o_out_z
);

    localparam int c_NREG = NUM_GP + NUM_SCR;

    logic [c_NREG-1:0]       w_en;
    logic [WIDTH-1:0]        w_q [c_NREG];
    logic [NUM_RD*WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]       w_rd_z;

    // Select buses are MSB-first: the top bit addresses R1 / S1.
    for (genvar k = 0; k < NUM_GP; k++) begin : g_gp_en
        assign w_en[k] = ~i_reg_sel[NUM_GP-1-k];
    end

    for (genvar k = 0; k < NUM_SCR; k++) begin : g_scr_en
        assign w_en[NUM_GP+k] = ~i_scr_sel[NUM_SCR-1-k];
    end

    for (genvar k = 0; k < c_NREG; k++) begin : g_cell
        rf_cell #(
            .WIDTH     (WIDTH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_en[k]),
            .i_fun_sel (i_fun_sel),
            .i_data    (i_data),
            .o_q       (w_q[k])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [SELW-1:0]  w_sel;
        logic [WIDTH-1:0] w_val;

        assign w_sel = i_out_sel[p*SELW +: SELW];

        // Unmatched (out-of-range) indices fall through to zero.
        always_comb begin
            w_val = '0;
            for (int k = 0; k < c_NREG; k++) begin
                if (w_sel == SELW'(k)) w_val = w_q[k];
            end
        end

        assign w_rd_data[p*WIDTH +: WIDTH] = w_val;
        assign w_rd_z[p]                   = (w_val == '0);
    end

`ifdef REG_FILE_OUT_REG_EN
    logic [NUM_RD*WIDTH-1:0] r_out;
    logic [NUM_RD-1:0]       r_out_z;

    // Flags reset to ones so they stay consistent with the cleared data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_out_z <= '1;
        end else begin
            r_out   <= w_rd_data;
            r_out_z <= w_rd_z;
        end
    end

    assign o_out   = r_out;
    assign o_out_z = r_out_z;
`else
    assign o_out   = w_rd_data;
    assign o_out_z = w_rd_z;
`endif

endmodule : reg_file_param

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// ============================================================================
// Module  : tb_reg_file_param
// Brief   : Directed self-checking bench for reg_file_param (default and
//           reduced parameter sets).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] data;
    logic [2:0]  fun_sel;
    logic [3:0]  reg_sel;
    logic [3:0]  scr_sel;
    logic [5:0]  out_sel;
    logic [31:0] out;
    logic [1:0]  outz;

    logic [7:0]  s_data;
    logic [2:0]  s_fun_sel;
    logic [2:0]  s_reg_sel;
    logic [1:0]  s_scr_sel;
    logic [8:0]  s_out_sel;
    logic [23:0] s_out;
    logic [2:0]  s_outz;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    reg_file_param u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (data),
        .i_fun_sel (fun_sel),
        .i_reg_sel (reg_sel),
        .i_scr_sel (scr_sel),
        .i_out_sel (out_sel),
        .o_out     (out),
        .o_out_z   (outz)
    );

    reg_file_param #(
        .WIDTH     (8),
        .NUM_GP    (3),
        .NUM_SCR   (2),
        .NUM_RD    (3)
    ) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .i_data    (s_data),
        .i_fun_sel (s_fun_sel),
        .i_reg_sel (s_reg_sel),
        .i_scr_sel (s_scr_sel),
        .i_out_sel (s_out_sel),
        .o_out     (s_out),
        .o_out_z   (s_outz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let a new OutSel reach the outputs (one edge when outputs are registered).
    task automatic settle();
`ifdef REG_FILE_OUT_REG_EN
        tick();
`else
        #1;
`endif
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                      input logic [15:0] d);
        fun_sel = fs;
        reg_sel = rs;
        scr_sel = ss;
        data    = d;
        tick();
        reg_sel = 4'hF;
        scr_sel = 4'hF;
    endtask

    task automatic rd(input int port, input int idx, input logic [15:0] exp, input string tag);
        out_sel[port*3 +: 3] = 3'(idx);
        settle();
        chk(tag, 64'(out[port*16 +: 16]), 64'(exp));
        chk({tag, "_z"}, 64'(outz[port]), 64'(exp == 16'h0));
    endtask

    initial begin
        rst       = 1'b1;
        data      = 16'h0;
        fun_sel   = 3'b010;
        reg_sel   = 4'hF;
        scr_sel   = 4'hF;
        out_sel   = {3'd7, 3'd0};
        s_data    = 8'h0;
        s_fun_sel = 3'b010;
        s_reg_sel = 3'b111;
        s_scr_sel = 2'b11;
        s_out_sel = 9'h0;
        #2;
        tick();
        tick();
        rst = 1'b0;

        // Prior contents, then reset with a simultaneous load that must lose.
        wr(3'b010, 4'h0, 4'h0, 16'h1111);
        rd(0, 0, 16'h1111, "pre_reset_R1");
        out_sel = {3'd7, 3'd0};
        fun_sel = 3'b010;
        data    = 16'hBEEF;
        reg_sel = 4'h0;
        scr_sel = 4'h0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        reg_sel = 4'hF;
        scr_sel = 4'hF;
        chk("reset_out", 64'(out), 64'h0);
        chk("reset_outz", 64'(outz), 64'h3);
        for (int k = 0; k < 8; k++) rd(k % 2, k, 16'h0000, "reset_sweep");

        // Modulo wrap on R1.
        wr(3'b010, 4'b0111, 4'hF, 16'hFFFF);
        rd(0, 0, 16'hFFFF, "wrap_load");
        wr(3'b001, 4'b0111, 4'hF, 16'h0);
        rd(0, 0, 16'h0000, "wrap_inc");
        wr(3'b000, 4'b0111, 4'hF, 16'h0);
        rd(0, 0, 16'hFFFF, "wrap_dec");

        // Half-word operations on R2.
        wr(3'b010, 4'b1011, 4'hF, 16'h1234);
        rd(1, 1, 16'h1234, "byte_init");
        wr(3'b101, 4'b1011, 4'hF, 16'hAB80);
        rd(1, 1, 16'h1280, "byte_wrlo");
        wr(3'b110, 4'b1011, 4'hF, 16'hAB80);
        rd(1, 1, 16'h8080, "byte_wrhi");
        wr(3'b111, 4'b1011, 4'hF, 16'hAB80);
        rd(1, 1, 16'hFF80, "byte_sx");
        wr(3'b100, 4'b1011, 4'hF, 16'hAB80);
        rd(1, 1, 16'h0080, "byte_zx");
        rd(0, 0, 16'hFFFF, "byte_R1_held");

        // All eight registers loaded at once, then selective updates.
        wr(3'b010, 4'h0, 4'h0, 16'h5A5A);
        for (int k = 0; k < 8; k++) rd((k + 1) % 2, k, 16'h5A5A, "multi_load");
        wr(3'b001, 4'b1110, 4'hF, 16'h0);
        rd(0, 3, 16'h5A5B, "held_R4_inc");
        rd(1, 0, 16'h5A5A, "held_R1");
        rd(1, 7, 16'h5A5A, "held_S4");
        wr(3'b011, 4'hF, 4'b0111, 16'h0);
        rd(0, 4, 16'h0000, "held_S1_clr");
        rd(1, 5, 16'h5A5A, "held_S2");
        rd(0, 3, 16'h5A5B, "held_R4_after_S");

        // Read-during-write on R3.
        rd(0, 2, 16'h5A5A, "rdw_before");
        fun_sel = 3'b010;
        data    = 16'h00FF;
        reg_sel = 4'b1101;
        #1;
        chk("rdw_pre_edge", 64'(out[15:0]), 64'h5A5A);
        tick();
        reg_sel = 4'hF;
`ifdef REG_FILE_OUT_REG_EN
        chk("rdw_reg_old", 64'(out[15:0]), 64'h5A5A);
        tick();
`endif
        chk("rdw_post_edge", 64'(out[15:0]), 64'h00FF);

        // Reduced parameter set: out-of-range selects and 8-bit wrap.
        s_out_sel = {3'd7, 3'd6, 3'd5};
        settle();
        chk("small_oor_out", 64'(s_out), 64'h0);
        chk("small_oor_outz", 64'(s_outz), 64'h7);
        s_fun_sel = 3'b010;
        s_data    = 8'hFF;
        s_reg_sel = 3'b011;
        tick();
        s_reg_sel = 3'b111;
        s_out_sel = {3'd7, 3'd6, 3'd0};
        settle();
        chk("small_load", 64'(s_out), 64'hFF);
        chk("small_load_z", 64'(s_outz), 64'h6);
        s_fun_sel = 3'b001;
        s_reg_sel = 3'b011;
        tick();
        s_reg_sel = 3'b111;
        settle();
        chk("small_wrap", 64'(s_out[7:0]), 64'h00);
        chk("small_wrap_z", 64'(s_outz), 64'h7);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_reg_file_param

`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised general-purpose/scratch register file, the next generation of the datapath register bank.
- Generalised in data width, number of general-purpose (R) and scratch (S) registers, and number of read ports.
- Adds synchronous reset, per-register function unit (count, load, clear, byte ops) and per-read-port zero flags.
- Sits between the ALU/memory result bus and the ALU operand muxes.

Parameters:
- WIDTH, 16, data width in bits; must be even, >= 4.
- NUM_GP, 4, number of general-purpose registers R1..R[NUM_GP].
- NUM_SCR, 4, number of scratch registers S1..S[NUM_SCR].
- NUM_RD, 2, number of independent read ports.
- SELW, derived $clog2(NUM_GP+NUM_SCR), read-select width; not overridable.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- I  in  WIDTH  write data, shared by all registers.
- FunSel  in  3  function applied to every enabled register.
- RegSel  in  NUM_GP  active-low enables; bit NUM_GP-1 = R1 ... bit 0 = R[NUM_GP].
- ScrSel  in  NUM_SCR  active-low enables; MSB = S1 ... LSB = S[NUM_SCR].
- OutSel  in  NUM_RD*SELW  port p select in bits [p*SELW +: SELW].
  - Index 0..NUM_GP-1 = R1..; NUM_GP.. = S1..
- Out  out  NUM_RD*WIDTH  port p data in bits [p*WIDTH +: WIDTH].
- OutZ  out  NUM_RD  port p: 1 when Out port p equals zero.

Behaviour:
- Reset (sync, high) clears every register to 0.
  - Reset overrides FunSel and all enables.
  - Out and OutZ follow register contents, so after reset Out = 0 and OutZ = all ones.
- A register with its select bit high holds its value.
- A register with its select bit low updates on the rising edge per FunSel (H = WIDTH/2):
  - 000 decrement, modulo 2^WIDTH: 0 -> all ones.
  - 001 increment, modulo: all ones -> 0.
  - 010 load I.
  - 011 clear to 0.
  - 100 Q = {H zeros, I[H-1:0]}.
  - 101 Q[H-1:0] = I[H-1:0]; upper half kept.
  - 110 Q[WIDTH-1:H] = I[H-1:0]; lower half kept.
  - 111 Q = sign-extend I[H-1:0] to WIDTH.
- Any number of registers may update in the same cycle; each applies the op to its own current value.
- Read ports are combinational from register outputs, 0-cycle latency.
  - A read of a register being written that cycle returns the pre-edge value; the new value is visible after the edge.
- An OutSel index >= NUM_GP+NUM_SCR drives Out = 0 and OutZ = 1.
- All read ports are independent; the same register may be read on every port.
- No X propagation: all case statements are fully specified with defaults.

Optional Feature:
- Macro REG_FILE_OUT_REG_EN.
- Defined:
  - Out and OutZ are registered, so read latency is 1 cycle (data visible the cycle after OutSel is applied).
  - Output registers clear on Reset.
  - Read-during-write returns the pre-edge value one cycle later.
- Undefined: purely combinational reads as above.

Decomposition:
- Package reg_file_pkg:
  - FunSel encodings: FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LOADLO_ZX, FS_WRLO, FS_WRHI, FS_LOADLO_SX.
  - Helper function computing SELW.
- Sub-module rf_cell: one WIDTH register with Reset, active-high E and FunSel datapath.
  - Instantiated NUM_GP+NUM_SCR times via generate.
  - The file inverts the active-low select bits.

Test Plan:
- Reset: any prior contents, Reset=1 for one edge -> all Out = 0x0000, OutZ = all ones; a FunSel=010 load in the same cycle is ignored.
- Wrap: R1=0xFFFF, FunSel=001, RegSel=0111 -> R1=0x0000, OutZ=1; then FunSel=000 -> R1=0xFFFF.
- Byte ops on R2=0x1234, I=0xAB80:
  - FunSel=101 -> 0x1280.
  - Then 110 -> 0x8080.
  - Then 111 -> 0xFF80.
  - Then 100 -> 0x0080.
- Multi-write: RegSel=0000, ScrSel=0000, FunSel=010, I=0x5A5A -> all eight registers read 0x5A5A across port sweeps; held registers remain unchanged when their selects are high.
- Read-during-write: OutSel port0 = R3, load 0x00FF into R3 -> Out0 shows the old value before the edge and 0x00FF after.
  - With REG_FILE_OUT_REG_EN, 0x00FF appears one cycle later.
- Parameter sweep: WIDTH=8, NUM_GP=3, NUM_SCR=2, NUM_RD=3 -> OutSel index 5..7 gives Out=0x00, OutZ=1; increment at 0xFF wraps to 0x00.
